// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA requester arbiter.
// Holds the arbiter state encoding and the default address/length widths.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    ZDONE     = 2'd3
  } arb_state_t;

  // Round-robin successor of idx among n requesters.
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dma_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o   = 1'b1;
        idx_o   = cand[IDX_W-1:0];
        grant_o = NUM_REQ'(1) << cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA channel among NUM_REQ requesters:
// accepts one descriptor, issues it, waits for completion, pulses req_done.
module dma_req_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DMA_ADDR_W,
  parameter int LEN_W   = DMA_LEN_W,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      dma_start,
  output logic [ADDR_W-1:0]         dma_addr,
  output logic [LEN_W-1:0]          dma_len,
  input  logic                      dma_ack,
  input  logic                      dma_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   complete;

  logic [ADDR_W-1:0]      addr_arr [NUM_REQ];
  logic [LEN_W-1:0]       len_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    done_d     = '0;
    complete   = 1'b0;
    req_ready  = '0;
    dma_start  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is suppressed under reset so no handshake is ever observed then.
        if (pick_any && !rst) begin
          req_ready  = pick_grant;
          grant_id_d = pick_idx;
          addr_d     = addr_arr[pick_idx];
          len_d      = len_arr[pick_idx];
          state_d    = (len_arr[pick_idx] == '0) ? ZDONE : ISSUE;
        end
      end
      ISSUE: begin
        dma_start = 1'b1;
        if (dma_ack) begin
          state_d  = WAIT_DONE;
          complete = dma_done;
        end
      end
      WAIT_DONE: complete = dma_done;
      ZDONE:     complete = 1'b1;
      default:   state_d  = IDLE;
    endcase

    if (complete) begin
      done_d   = NUM_REQ'(1) << grant_id_q;
      rr_ptr_d = IDX_W'(next_rr(int'(grant_id_q), NUM_REQ));
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      done_q     <= done_d;
    end
  end

  assign req_done = done_q;
  assign dma_addr = addr_q;
  assign dma_len  = len_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed and randomized bench for dma_req_arbiter against a transaction-level
// model: winner chosen by modular search from a pointer, timing from the protocol rules.
module tb_dma_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [63:0]  req_len;
  logic [3:0]   req_ready;
  logic [3:0]   req_done;
  logic         dma_start;
  logic [31:0]  dma_addr;
  logic [15:0]  dma_len;
  logic         dma_ack;
  logic         dma_done;
  logic         busy;
  logic [1:0]   grant_id;

  dma_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .LEN_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .req_done  (req_done),
    .dma_start (dma_start),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_ack   (dma_ack),
    .dma_done  (dma_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ptr_m  = 0;
  logic [3:0]  pend_m = '0;
  logic [31:0] addr_t [4];
  logic [15:0] len_t  [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++) begin
      if (mask[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit stray);
    tick();
    req_valid = '0;
    dma_ack   = 1'b0;
    dma_done  = stray;
    #1;
    chk("idle_req_done", req_done, pend_m);
    pend_m = '0;
    chk("idle_busy", busy, 0);
    chk("idle_start", dma_start, 0);
    chk("idle_ready", req_ready, 0);
    $display("idle cycle stray_done=%0d req_done=%b", stray, req_done);
  endtask

  // One full transaction starting from an IDLE cycle. Returns during the last
  // active cycle; the following task's tick enters the req_done cycle.
  task automatic start_txn(input logic [3:0] mask, input bit keep, input int ack_dly,
                           input int done_dly, input bit same, input bit stray);
    int          w;
    logic [3:0]  oh;
    tick();
    req_valid = mask;
    dma_ack   = 1'b0;
    dma_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = addr_t[i];
      req_len[i*16 +: 16]  = len_t[i];
    end
    #1;
    w  = winner(mask, ptr_m);
    oh = 4'(1) << w;
    chk("hs_req_done", req_done, pend_m);
    pend_m = '0;
    chk("hs_busy", busy, 0);
    chk("hs_ready", req_ready, oh);
    chk("hs_start", dma_start, 0);

    tick();
    if (!keep) req_valid = '0;
    #1;
    chk("lat_busy", busy, 1);
    chk("lat_grant", grant_id, w);
    chk("lat_addr", dma_addr, addr_t[w]);
    chk("lat_len", dma_len, len_t[w]);
    chk("lat_ready", req_ready, 0);
    chk("lat_done", req_done, 0);
    $display("txn mask=%b winner=%0d addr=%h len=%0d ack_dly=%0d done_dly=%0d same=%0d",
             mask, w, addr_t[w], len_t[w], ack_dly, done_dly, same);
    ptr_m = (w + 1) % 4;

    if (len_t[w] == 0) begin
      chk("zlen_start", dma_start, 0);
      pend_m = oh;
      return;
    end

    chk("issue_start", dma_start, 1);
    for (int i = 0; i < ack_dly; i++) begin
      dma_done = stray && (i == 0);
      tick();
      dma_done = 1'b0;
      #1;
      chk("wait_ack_start", dma_start, 1);
      chk("wait_ack_done", req_done, 0);
    end
    dma_ack  = 1'b1;
    dma_done = same;
    #1;
    chk("ack_start", dma_start, 1);
    if (same) begin
      pend_m = oh;
      return;
    end

    tick();
    dma_ack = 1'b0;
    #1;
    chk("wd_start", dma_start, 0);
    chk("wd_busy", busy, 1);
    chk("wd_grant", grant_id, w);
    for (int i = 0; i < done_dly - 1; i++) begin
      tick();
      #1;
      chk("wd_hold_busy", busy, 1);
      chk("wd_hold_done", req_done, 0);
      chk("wd_hold_addr", dma_addr, addr_t[w]);
    end
    dma_done = 1'b1;
    pend_m   = oh;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    dma_ack   = 1'b0;
    dma_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_start", dma_start, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_len", dma_len, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", req_done, 0);
    chk("rst_ready", req_ready, 0);
    $display("reset released");

    // Fairness: all valid, immediate ack+done; expect 0,1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      addr_t[i] = 32'h100 * (i + 1);
      len_t[i]  = 16'(i + 1);
    end
    for (int n = 0; n < 5; n++) start_txn(4'b1111, 1'b1, 0, 1, 1'b1, 1'b0);
    idle_cycle(1'b0);

    // Single request on requester 2.
    addr_t[2] = 32'h1000;
    len_t[2]  = 16'd64;
    start_txn(4'b0100, 1'b0, 3, 10, 1'b0, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // Zero length on requester 1.
    len_t[1] = 16'd0;
    start_txn(4'b0010, 1'b0, 0, 1, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Ack and done together, plus a stray done without ack and one in IDLE.
    len_t[3] = 16'd7;
    start_txn(4'b1001, 1'b0, 2, 1, 1'b1, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Reset while waiting for completion.
    addr_t[3] = 32'hDEAD_BEEF;
    len_t[3]  = 16'd5;
    tick();
    req_valid = 4'b1000;
    req_addr[96 +: 32] = addr_t[3];
    req_len[48 +: 16]  = len_t[3];
    #1;
    chk("abort_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    dma_ack   = 1'b1;
    #1;
    chk("abort_issue", dma_start, 1);
    tick();
    dma_ack = 1'b0;
    #1;
    chk("abort_wd_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_start", dma_start, 0);
    chk("abort_addr", dma_addr, 0);
    chk("abort_len", dma_len, 0);
    chk("abort_grant", grant_id, 0);
    chk("abort_done", req_done, 0);
    $display("reset during WAIT_DONE applied");
    ptr_m  = 0;
    pend_m = '0;
    dma_done = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    for (int i = 0; i < 4; i++) len_t[i] = 16'd3;
    start_txn(4'b1111, 1'b0, 1, 2, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 4; i++) begin
        addr_t[i] = $urandom;
        len_t[i]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      end
      start_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_req_arbiter.md
# dma_req_arbiter

Round-robin arbiter and command sequencer that shares the single DMA controller channel among up to `NUM_REQ` requesters (weight loader, dimension/bias loader, image loader, output writer). It accepts one transfer descriptor at a time, issues it to the DMA controller, holds the grant until the DMA reports completion, then signals the owning requester. It sits between the CPU-side load FSMs and the DMA controller.

## Interface
- `NUM_REQ`, 4: number of requesters. Legal range is 2..8.
- `ADDR_W`, 32: width of the transfer address.
- `LEN_W`, 16: width of the transfer length, in words.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i holds a valid descriptor.
- `req_addr` in `NUM_REQ*ADDR_W`: packed addresses. Requester i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_len` in `NUM_REQ*LEN_W`: packed lengths. Same packing as `req_addr`.
- `req_ready` out `NUM_REQ`: one-hot descriptor accept.
- `req_done` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `dma_start` out 1: command valid toward the DMA controller.
- `dma_addr` out `ADDR_W`: latched address.
- `dma_len` out `LEN_W`: latched length.
- `dma_ack` in 1: DMA controller accepted the command.
- `dma_done` in 1: one-cycle pulse, transfer finished.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out `$clog2(NUM_REQ)`: current owner. Holds the last owner while in IDLE.

## Operation
- FSM `arb_state_t` has four states: IDLE, ISSUE, WAIT_DONE, ZDONE.
- Requester selection in IDLE:
  - Winner = first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping past `NUM_REQ-1` to 0.
  - `req_ready[winner]` is driven combinationally, only in IDLE. The handshake completes when valid and ready are both high.
- On handshake:
  - Latch addr and len into `dma_addr`/`dma_len`. Set `grant_id` = winner.
  - If len != 0, go to ISSUE. If len == 0, go to ZDONE.
- ISSUE:
  - `dma_start` = 1 and is held until `dma_ack` is sampled high.
  - On ack alone, go to WAIT_DONE.
  - On ack and `dma_done` in the same cycle, treat as completion (see below).
  - `dma_done` without ack is ignored.
- WAIT_DONE: on `dma_done`, completion.
- Completion (also the action taken in ZDONE):
  - Register a `req_done[grant_id]` pulse for the next cycle.
  - `rr_ptr` <= (`grant_id`+1) mod `NUM_REQ`.
  - Go to IDLE.
- `dma_done` received in IDLE is ignored.
- `req_valid` deasserting in ISSUE or WAIT_DONE has no effect. The descriptor was already accepted.
- Reset (any state, including mid-transfer):
  - State IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - `dma_addr`/`dma_len` = 0. All outputs 0.
  - A late `dma_done` from the aborted transfer is ignored.

## Timing
- `req_valid` high in IDLE → `req_ready` the same cycle → `dma_start` high the next cycle.
- `dma_ack` high in cycle N → `dma_start` low in N+1.
- `dma_done` in cycle N → `req_done` high in N+1 and state IDLE in N+1. The next grant's `dma_start` is earliest in N+2.
- Zero-length descriptor: handshake in N → ZDONE in N+1 → `req_done` in N+2. `dma_start` is never asserted.
- `dma_addr`, `dma_len` and `grant_id` are stable from the first ISSUE cycle until the next handshake.
- There are no combinational paths from `dma_*` inputs to `dma_*` outputs.

## Structure
- Shared package `dma_pkg`:
  - `arb_state_t`.
  - Default constants `DMA_ADDR_W` = 32 and `DMA_LEN_W` = 16, used as parameter defaults.
- One sub-module, `rr_pick`, is natural:
  - Purely combinational.
  - Inputs: `NUM_REQ`-bit request vector and `rr_ptr`.
  - Outputs: one-hot grant and encoded index.
- FSM, latches and `rr_ptr` stay in `dma_req_arbiter`.

## Test plan
- Single request: req 2 presents addr 0x1000, len 64 → `req_ready[2]` the same cycle; `dma_start` with 0x1000/64 the next cycle. Ack after 3 cycles; `dma_done` 10 cycles later → `req_done` = 4'b0100 one cycle later.
- Fairness: all four requesters valid continuously, `dma_ack` and `dma_done` immediate → grant order 0,1,2,3,0. `rr_ptr` wraps from 3 to 0.
- Zero length: req 1 with len 0 → `dma_start` never asserted; `req_done[1]` two cycles after the handshake.
- Simultaneous ack and done in ISSUE → WAIT_DONE skipped; `req_done` in the next cycle. A stray `dma_done` in IDLE produces no `req_done`.
- Reset mid-WAIT_DONE: `rst` high for one cycle, then `dma_done` → no `req_done`. All outputs are 0 after reset. The next grant starts searching at index 0.
